// File: rtl/sync_rr_merge.sv
// Round-robin merge of NUM_WAYS interleaved FIFO ways into one in-order stream,
// decoupled from the consumer by a 2-entry output buffer.
module sync_rr_merge #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WAYS = 2,
  localparam int LB_NUM_WAYS = $clog2(NUM_WAYS)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           clear,
  input  logic [NUM_WAYS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_WAYS-1:0]            in_valid,
  output logic [NUM_WAYS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LB_NUM_WAYS-1:0]         sel,
  output logic [1:0]                     count
);

  logic [LB_NUM_WAYS-1:0] ptr_reg;
  logic [LB_NUM_WAYS-1:0] ptr_next;
  logic [1:0]             count_reg;
  logic                   wr_reg;
  logic                   rd_reg;
  logic [DATA_WIDTH-1:0]  slot_reg [2];
  logic [DATA_WIDTH-1:0]  way_data [NUM_WAYS];
  logic                   has_room;
  logic                   take;
  logic                   pop;

  // in_ready is a pure function of registers, so it never depends on out_ready.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      assign way_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign in_ready[gi] = has_room && (ptr_reg == LB_NUM_WAYS'(gi));
    end
  endgenerate

  assign has_room  = (count_reg != 2'd2);
  assign take      = in_valid[ptr_reg] && has_room;
  assign pop       = (count_reg != 2'd0) && out_ready;
  assign ptr_next  = (ptr_reg == LB_NUM_WAYS'(NUM_WAYS-1)) ? '0 : ptr_reg + 1'b1;

  assign out_valid = (count_reg != 2'd0);
  assign out_data  = slot_reg[rd_reg];
  assign sel       = ptr_reg;
  assign count     = count_reg;

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      ptr_reg   <= '0;
      count_reg <= 2'd0;
      wr_reg    <= 1'b0;
      rd_reg    <= 1'b0;
    end else begin
      if (take) begin
        ptr_reg <= ptr_next;
        wr_reg  <= ~wr_reg;
      end
      if (pop) begin
        rd_reg <= ~rd_reg;
      end
      case ({take, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Slot contents need no reset: a slot is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (take) begin
      slot_reg[wr_reg] <= way_data[ptr_reg];
    end
  end

endmodule
